gearbox_frame_arbiter: RTL

- Shares the 32->24 gearbox input between two 32-bit RGB frame sources.
- Arbitrates round-robin at frame granularity, so a grant is held until the frame's last word.
- Enforces a maximum frame length by truncating and discarding overlong frames.
- Inserts a programmable idle gap between frames so the gearbox can flush its residue; sits directly in front of the gearbox input (data_en / data_in_last / data_in_rgb).

---
 rtl/gearbox_frame_arbiter.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gearbox_frame_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gearbox_frame_arbiter
//
// Shares the 32->24 gearbox input between two 32-bit RGB frame sources.
// Ownership is granted round-robin per frame and held until the frame's last
// word. Frames longer than MAX_WORDS are cut at MAX_WORDS (the cut word is
// flagged last) and the remainder is swallowed. After every frame, GAP_CYCLES
// idle cycles give the gearbox time to flush its residue.
//
// Ports
//   clk_200m      in   1   clock, rising edge
//   reset         in   1   asynchronous active-low reset
//   s_valid       in   2   per-source word valid
//   s_last        in   2   per-source last word of frame
//   s_data0/1     in  32   source 0/1 RGB word
//   s_ready       out  2   per-source accept
//   gb_ready      in   1   gearbox accepts the presented word
//   data_en       out  1   output word valid (held until gb_ready)
//   data_in_last  out  1   last word of the output frame
//   data_in_rgb   out 32   output word
//   grant         out  2   one-hot frame owner, 0 when unowned
//   busy          out  1   high outside IDLE
//   frame_cnt0/1  out 16   completed frames per source (wrapping)
//   truncate_err  out  1   one-cycle pulse when a frame is cut
// -----------------------------------------------------------------------------
module gearbox_frame_arbiter #(
    parameter logic [15:0] MAX_WORDS  = 16'd9012,
    parameter logic [7:0]  GAP_CYCLES = 8'd4
) (
    input  logic        clk_200m,
    input  logic        reset,
    input  logic [1:0]  s_valid,
    input  logic [1:0]  s_last,
    input  logic [31:0] s_data0,
    input  logic [31:0] s_data1,
    output logic [1:0]  s_ready,
    input  logic        gb_ready,
    output logic        data_en,
    output logic        data_in_last,
    output logic [31:0] data_in_rgb,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1,
    output logic        truncate_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS  = 3'd1,
        ST_DROP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        owner_q, owner_d;      // index of the last/current granted source
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        dat_en_q, dat_en_d;
    logic        dat_last_q, dat_last_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] fcnt0_q, fcnt0_d;
    logic [15:0] fcnt1_q, fcnt1_d;
    logic        trunc_q, trunc_d;
    logic        busy_q, busy_d;

    logic        sel_valid_s;
    logic        sel_last_s;
    logic [31:0] sel_data_s;
    logic        out_free_s;
    logic [15:0] word_num_s;
    logic        is_final_s;
    logic [7:0]  gap_next_s;
    logic [1:0]  s_ready_s;
    logic        load_s;
    logic        load_last_s;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Select the owning source's request and decode the final-word condition.
    always_comb begin
        sel_valid_s = s_valid[owner_q];
        sel_last_s  = s_last[owner_q];
        sel_data_s  = owner_q ? s_data1 : s_data0;
        out_free_s  = !dat_en_q || gb_ready;
        word_num_s  = word_cnt_q + 16'd1;
        is_final_s  = sel_last_s || (word_num_s == MAX_WORDS);
        gap_next_s  = gap_cnt_q + 8'd1;
    end

    // Frame FSM next state, arbitration, counters and input handshake.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        fcnt0_d     = fcnt0_q;
        fcnt1_d     = fcnt1_q;
        trunc_d     = 1'b0;
        s_ready_s   = 2'b00;
        load_s      = 1'b0;
        load_last_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|s_valid) begin
                    // With two requesters the one not served last wins.
                    if (&s_valid) begin
                        owner_d = ~owner_q;
                    end else begin
                        owner_d = s_valid[1];
                    end
                    grant_d = onehot2(owner_d);
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                s_ready_s = onehot2(owner_q) & {2{out_free_s}};
                if (sel_valid_s && out_free_s) begin
                    load_s      = 1'b1;
                    load_last_s = is_final_s;
                    word_cnt_d  = word_num_s;
                    if (is_final_s) begin
                        if (sel_last_s) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_DROP;
                            trunc_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_PASS;
                    end
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_DROP: begin
                s_ready_s = onehot2(owner_q);
                if (sel_valid_s && sel_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DRAIN: begin
                // Only the frame's last word can be in the output register here.
                // After a long DROP it may already have left, so an empty
                // register also completes the frame.
                if (out_free_s) begin
                    if (owner_q) begin
                        fcnt1_d = fcnt1_q + 16'd1;
                    end else begin
                        fcnt0_d = fcnt0_q + 16'd1;
                    end
                    grant_d    = 2'b00;
                    word_cnt_d = 16'd0;
                    gap_cnt_d  = 8'd0;
                    if (GAP_CYCLES == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_next_s;
                if (gap_next_s == GAP_CYCLES) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = 2'b00;
                word_cnt_d = 16'd0;
                gap_cnt_d  = 8'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Output register: load an accepted word, else clear once the gearbox takes it.
    always_comb begin
        if (load_s) begin
            dat_en_d   = 1'b1;
            dat_d      = sel_data_s;
            dat_last_d = load_last_s;
        end else if (gb_ready) begin
            dat_en_d   = 1'b0;
            dat_d      = dat_q;
            dat_last_d = 1'b0;
        end else begin
            dat_en_d   = dat_en_q;
            dat_d      = dat_q;
            dat_last_d = dat_last_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_200m or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            owner_q    <= 1'b1;
            word_cnt_q <= 16'd0;
            gap_cnt_q  <= 8'd0;
            dat_en_q   <= 1'b0;
            dat_last_q <= 1'b0;
            dat_q      <= 32'd0;
            fcnt0_q    <= 16'd0;
            fcnt1_q    <= 16'd0;
            trunc_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            dat_en_q   <= dat_en_d;
            dat_last_q <= dat_last_d;
            dat_q      <= dat_d;
            fcnt0_q    <= fcnt0_d;
            fcnt1_q    <= fcnt1_d;
            trunc_q    <= trunc_d;
            busy_q     <= busy_d;
        end
    end

    assign s_ready      = s_ready_s;
    assign data_en      = dat_en_q;
    assign data_in_last = dat_last_q;
    assign data_in_rgb  = dat_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign frame_cnt0   = fcnt0_q;
    assign frame_cnt1   = fcnt1_q;
    assign truncate_err = trunc_q;

endmodule
